mux_sel_pipe: RTL
=================

Name: mux_sel_pipe

Overview:
Parametrised, registered N-input, W-bit selector for the Execute-stage ALU datapath. It generalises the existing single-bit 4:1 gate-level mux to arbitrary width and input count. The selected operand is placed into a one-entry output register with a valid/ready handshake, so result selection can be pipelined between the ALU function units and the writeback path. It adds out-of-range select detection and a beat counter for bring-up.

Parameters:
WIDTH, 64, bit width of each data input and of out_data
NUM_IN, 4, number of data inputs; legal range 2..16
SEL_W, 2, width of sel; must satisfy 2^SEL_W >= NUM_IN (elaboration-time error otherwise)
CNT_W, 16, width of beat_cnt

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents sel/data_in this cycle
in_ready  output  1  block can accept a beat this cycle
sel  input  SEL_W  input index; value k selects input k (0 selects input 0, 3 selects input 3, same encoding as the 4:1 mux)
data_in  input  NUM_IN*WIDTH  flattened inputs; input k = data_in[k*WIDTH +: WIDTH]
out_valid  output  1  out_data/out_sel/sel_err hold a valid beat
out_ready  input  1  downstream accepts the beat this cycle
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_W  sel value captured with the beat
sel_err  output  1  captured beat had sel >= NUM_IN
beat_cnt  output  CNT_W  count of accepted input beats, wrapping

Behaviour:
- Reset (async assert, sync release on clk): out_valid=0, out_data=0, out_sel=0, sel_err=0, beat_cnt=0. in_ready=1 during and after reset.
- in_ready = !out_valid || out_ready. This is combinational from out_ready. There is no combinational path from in_valid or data_in to any output.
- Accept: in_valid && in_ready at a rising edge. On the next cycle:
  - out_valid=1
  - out_data = input[sel]
  - out_sel = sel
  - sel_err = (sel >= NUM_IN)
- Latency is exactly 1 cycle from accept to out_valid.
- Out-of-range sel (only possible when NUM_IN < 2^SEL_W): out_data=0 and sel_err=1. The beat is still delivered and counted.
- Drain: out_valid && out_ready with no accept in the same edge gives out_valid=0 next cycle. out_data, out_sel and sel_err keep their last values (don't-care to consumers).
- Stall: out_valid && !out_ready gives in_ready=0. out_data, out_sel and sel_err hold bit-stable until the beat is taken. No upstream beat is dropped or overwritten.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the register reloads with the new beat and out_valid stays 1. This gives full throughput of 1 beat/cycle.
- beat_cnt increments by 1 on every accept and wraps from 2^CNT_W-1 to 0. There is no saturation and no separate clear; only rst clears it.
- in_valid while in_ready=0: the block ignores it and it is not counted. Upstream must hold the beat.
- Reset asserted mid-stall: the held beat is discarded, all outputs return to reset values immediately (asynchronously), and beat_cnt=0.
- X on sel or data_in while in_valid=0 must not propagate to any output.

Test Plan:
1. Reset then single beat: WIDTH=64, NUM_IN=4, out_ready=1; in_valid=1 for one cycle with sel=2 and input2=64'hDEAD_BEEF_0000_0002 -> next cycle out_valid=1, out_data=64'hDEAD_BEEF_0000_0002, out_sel=2, sel_err=0, beat_cnt=1; the cycle after, out_valid=0.
2. Streaming: out_ready=1; 8 back-to-back beats with sel cycling 0,1,2,3,0,1,2,3 and inputs k=k+1 -> out_data sequence 1,2,3,4,1,2,3,4 on consecutive cycles; in_ready never drops; beat_cnt=8.
3. Backpressure: send sel=1 (value 0x11), then hold out_ready=0 for 3 cycles while in_valid=1 with sel=3 (value 0x33) -> in_ready=0 and out_data=0x11 stable for 3 cycles; when out_ready=1, 0x33 appears the next cycle; beat_cnt=2, nothing lost.
4. Out-of-range select: NUM_IN=3, SEL_W=2, sel=3 with all inputs 0xFF -> out_data=0, sel_err=1, out_sel=3, beat_cnt increments; a following beat with sel=0 gives sel_err=0.
5. Counter wrap: CNT_W=4; 17 accepted beats -> beat_cnt goes 15 then 0 then 1.
6. Async reset mid-stall: out_valid=1, out_ready=0, beat_cnt=5; pulse rst between clock edges -> out_valid, out_data, sel_err and beat_cnt are 0 before the next edge; the first beat after release has 1-cycle latency.

Source files
------------

// File: rtl/mux_sel_pipe.sv
// Registered N:1 operand selector with a one-entry valid/ready output stage.
// Flags out-of-range selects and counts accepted beats for bring-up.
module mux_sel_pipe #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        beat_cnt
);

  generate
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("mux_sel_pipe: NUM_IN must be in 2..16");
    end
    if ((1 << SEL_W) < NUM_IN) begin : g_bad_sel_w
      $error("mux_sel_pipe: SEL_W too narrow for NUM_IN");
    end
  endgenerate

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_sel;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic [WIDTH-1:0]    w_sel_data;
  logic                w_oor;
  logic                w_accept;

  // Unmatched select values fall through to zero data.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_sel_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign w_oor    = ({{(32-SEL_W){1'b0}}, sel} >= 32'(NUM_IN));
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_sel   <= sel;
        r_err   <= w_oor;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (out_ready) begin
        // Drain only clears valid; payload fields are left as-is.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign sel_err   = r_err;
  assign beat_cnt  = r_cnt;

endmodule
